hit_retime: RTL and testbench
=============================

// Module: hit_retime
// PURPOSE
//  Two-stage retiming/qualification pipe between sample test (R16) and the z-buffer model (R18).
//  - Takes the sample test result: sample location, triangle, colour, hit flag.
//  - Forms the hit vector {x,y,z} and drops hits outside the screen.
//  - Presents registered hit_R18S / color_R18U / hit_valid_R18H to zbuff.
//  - Honours the global halt so the raster pipe can be back-pressured.
// PARAMETERS
//  SIGFIG   24  bits in colour and position
//  RADIX    10  fraction bits in colour and position
//  VERTS    3   vertices per triangle
//  AXIS     3   axes per vertex (x,y,z)
//  COLORS   3   colour channels
//  PIPE_DEP 2   register stages R16->R18; fixed at 2, elaboration error otherwise
// PORTS
//  clk              in   1                       clock
//  rst              in   1                       synchronous reset, active-high
//  halt_RnnnnL      in   1                       0 = hold every stage (stall)
//  screen_RnnnnS    in   [1:0][SIGFIG]           screen width/height, fixed point signed
//  tri_R16S         in   [VERTS][AXIS][SIGFIG]   triangle under test; z taken from vertex 0
//  color_R16U       in   [COLORS][SIGFIG]        triangle colour
//  sample_R16S      in   [1:0][SIGFIG]           sample location x,y
//  validSamp_R16H   in   1                       sample slot carries real data
//  hit_R16H         in   1                       sample inside triangle
//  hit_R18S         out  [1][AXIS][SIGFIG]       {x,y,z} of hit (MULTI_SAMP=1 view)
//  color_R18U       out  [COLORS][SIGFIG]        colour of hit
//  hit_valid_R18H   out  [1]                     hit qualifier
//  clip_cnt_RnnnnU  out  32                      hits dropped by screen guard
// BEHAVIOUR
//  - Reset (rst=1 at posedge):
//    - hit_valid_R17H, hit_valid_R18H <= 0; hit/colour data regs <= 0.
//    - clip_cnt <= 0. Reset takes priority over halt.
//  - Latency: exactly 2 enabled cycles. Stage advances only on posedge with halt_RnnnnL=1.
//  - halt_RnnnnL=0: all data and valid regs hold; outputs stable, including a held valid=1.
//    - zbuff samples on every clk, so a held valid hit is re-presented each halted cycle.
//    - This is intended: a repeated identical fragment is idempotent in the z-test.
//  - R16->R17 qualification:
//    - q = validSamp & hit.
//    - guard = (x >= 0) & (y >= 0) & (x < screen[0]) & (y < screen[1]); full SIGFIG signed compares.
//    - hit_valid_R17H <= q & guard.
//    - hit_R17S <= {sample x, sample y, tri[0][2]}.
//    - colour <= color_R16U. Data regs load every enabled cycle regardless of q.
//  - Dropped hit (q & ~guard) on an enabled cycle: clip_cnt += 1, saturating at 32'hFFFF_FFFF.
//  - R17->R18: pure register copy, enabled by halt.
//  - Simultaneous rst and halt=0: reset wins.
//  - Screen change mid-stream: guard uses the current screen_RnnnnS. No retro-check of in-flight hits.
// CONFIGURATION
//  HIT_STATS_EN:
//  - Defined: adds output hit_cnt_RnnnnU[31:0].
//    - Counts hits leaving R18 (hit_valid_R18H=1 on an enabled cycle).
//    - Saturating; reset to 0.
//  - Undefined: the port and its counter are absent. clip_cnt_RnnnnU is always present.
// STRUCTURE
//  - Shared package rast_pkg (already shared with the rest of the raster pipe):
//    - SIGFIG, RADIX, AXIS, COLORS constants.
//    - typedef logic signed [SIGFIG-1:0] fixp_t.
//    - typedef fixp_t vert_t[AXIS].
//  - One sub-module: sat_cnt32 (enable, rst, saturating count).
//    - Used for clip_cnt and, under HIT_STATS_EN, hit_cnt.
//  - The two pipe stages are inline, in one always_ff per stage.
// TESTING
//  1. Reset, then one hit at sample (5.0,7.0), z=0x1234, screen 640x480:
//     - hit_valid_R18H=1 exactly 2 cycles later, hit_R18S={5<<10, 7<<10, 0x1234}.
//  2. validSamp=1, hit=0:
//     - hit_valid_R18H stays 0; clip_cnt unchanged.
//  3. Hit at x=640.0 on a 640-wide screen, and a hit at x=-1.0:
//     - neither reaches R18; clip_cnt=2.
//  4. Hit in R17, then halt_RnnnnL=0 for 3 cycles, then 1:
//     - outputs frozen during the halt.
//     - Hit appears at R18 on the first enabled cycle after release.
//     - No other output change.
//  5. Back-to-back hits every cycle for 100 cycles:
//     - 100 valid R18 outputs in order, 2-cycle offset.
//     - With HIT_STATS_EN, hit_cnt=100.
//  6. rst asserted while valid hits sit in R17/R18:
//     - both valids 0 on the next cycle; counters 0.
//     - The next hit after reset emerges after 2 cycles.

Source files
------------

// File: rtl/rast_pkg.sv
// ---------------------------------------------------------------------------
// rast_pkg: fixed-point types and constants shared by the raster pipe.
//   SIGFIG/RADIX : word width and fraction bits for colour and position
//   VERTS/AXIS   : vertices per triangle, axes per vertex (x,y,z)
//   COLORS       : colour channels
//   on_screen()  : screen guard used where sample hits get qualified
// ---------------------------------------------------------------------------
package rast_pkg;

    localparam int unsigned SIGFIG = 24;
    localparam int unsigned RADIX  = 10;
    localparam int unsigned VERTS  = 3;
    localparam int unsigned AXIS   = 3;
    localparam int unsigned COLORS = 3;
    localparam int unsigned CNT_W  = 32;

    // Axis positions inside a vertex / hit vector.
    localparam int unsigned AX_X = 0;
    localparam int unsigned AX_Y = 1;
    localparam int unsigned AX_Z = 2;

    typedef logic signed [SIGFIG-1:0] fixp_t;
    typedef fixp_t                    vert_t [AXIS];
    typedef logic        [SIGFIG-1:0] chan_t;
    typedef logic        [CNT_W-1:0]  cnt_t;

    // True when (x,y) lies in [0,w) x [0,h); full-width signed compares.
    function automatic logic on_screen(input fixp_t x, input fixp_t y,
                                       input fixp_t w, input fixp_t h);
        logic x_pos;
        logic y_pos;
        x_pos = ~x[SIGFIG-1];
        y_pos = ~y[SIGFIG-1];
        return x_pos & y_pos & (x < w) & (y < h);
    endfunction

endpackage : rast_pkg

// File: rtl/hit_retime_sat_cnt32.sv
// ---------------------------------------------------------------------------
// sat_cnt32: 32-bit event counter that sticks at all-ones.
//   clk   : clock
//   rst   : synchronous reset, active-high, clears the count
//   en    : count one event this cycle
//   count : registered count value
// ---------------------------------------------------------------------------
module sat_cnt32
    import rast_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    output cnt_t count
);

    // Increment unless already saturated.
    always_ff @(posedge clk) begin : p_cnt
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : sat_cnt32

// File: rtl/hit_retime.sv
// ---------------------------------------------------------------------------
// hit_retime: two-stage retime/qualify pipe from sample test (R16) to zbuff
// (R18). Builds the {x,y,z} hit vector, drops hits that fall off screen and
// counts them, and stalls every stage while halt_RnnnnL is low.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset (wins over halt)
//   halt_RnnnnL      : 1 = advance, 0 = hold all stages
//   screen_RnnnnS    : screen width [0] / height [1], signed fixed point
//   tri_R16S         : triangle vertices; z is taken from vertex 0
//   color_R16U       : triangle colour
//   sample_R16S      : sample x [0] / y [1]
//   validSamp_R16H   : sample slot carries real data
//   hit_R16H         : sample is inside the triangle
//   hit_R18S         : registered {x,y,z} of the hit
//   color_R18U       : registered colour of the hit
//   hit_valid_R18H   : registered hit qualifier
//   clip_cnt_RnnnnU  : saturating count of hits dropped by the screen guard
//   hit_cnt_RnnnnU   : saturating count of hits leaving R18 (HIT_STATS_EN only)
//
// Configuration macro: HIT_STATS_EN adds hit_cnt_RnnnnU and its counter.
// A held valid hit is re-presented every halted cycle; zbuff treats the
// repeated fragment as idempotent.
// ---------------------------------------------------------------------------
module hit_retime
    import rast_pkg::*;
#(
    parameter int unsigned PIPE_DEP = 2
)
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              halt_RnnnnL,
    input  fixp_t [1:0]                       screen_RnnnnS,
    input  fixp_t [VERTS-1:0][AXIS-1:0]       tri_R16S,
    input  chan_t [COLORS-1:0]                color_R16U,
    input  fixp_t [1:0]                       sample_R16S,
    input  logic                              validSamp_R16H,
    input  logic                              hit_R16H,
    output fixp_t [0:0][AXIS-1:0]             hit_R18S,
    output chan_t [COLORS-1:0]                color_R18U,
    output logic  [0:0]                       hit_valid_R18H,
`ifdef HIT_STATS_EN
    output cnt_t                              hit_cnt_RnnnnU,
`endif
    output cnt_t                              clip_cnt_RnnnnU
);

    // The stage count is baked into the inline register chain below.
    if (PIPE_DEP != 2) begin : g_bad_pipe_dep
        $error("hit_retime: PIPE_DEP must be 2");
    end

    logic                   en_c;
    logic                   qual_c;
    logic                   guard_c;
    logic                   drop_c;
    logic                   unused_tri_c;

    logic                   hit_valid_R17H;
    fixp_t [AXIS-1:0]       hit_R17S;
    chan_t [COLORS-1:0]     color_R17U;

    // Stage enable and hit qualification at R16.
    assign en_c    = halt_RnnnnL;
    assign qual_c  = validSamp_R16H & hit_R16H;
    assign guard_c = on_screen(sample_R16S[0], sample_R16S[1],
                               screen_RnnnnS[0], screen_RnnnnS[1]);
    assign drop_c  = en_c & qual_c & ~guard_c;

    // Only vertex 0 z contributes to the hit vector.
    assign unused_tri_c = ^{tri_R16S[2], tri_R16S[1],
                            tri_R16S[0][AX_Y], tri_R16S[0][AX_X]};

    // R16 -> R17: qualify and form the hit vector; data loads even when not valid.
    always_ff @(posedge clk) begin : p_r17
        if (rst) begin
            hit_valid_R17H <= 1'b0;
            hit_R17S       <= '0;
            color_R17U     <= '0;
        end else if (en_c) begin
            hit_valid_R17H   <= qual_c & guard_c;
            hit_R17S[AX_X]   <= sample_R16S[0];
            hit_R17S[AX_Y]   <= sample_R16S[1];
            hit_R17S[AX_Z]   <= tri_R16S[0][AX_Z];
            color_R17U       <= color_R16U;
        end
    end

    // R17 -> R18: plain retiming copy.
    always_ff @(posedge clk) begin : p_r18
        if (rst) begin
            hit_valid_R18H <= '0;
            hit_R18S       <= '0;
            color_R18U     <= '0;
        end else if (en_c) begin
            hit_valid_R18H[0] <= hit_valid_R17H;
            hit_R18S[0]       <= hit_R17S;
            color_R18U        <= color_R17U;
        end
    end

    // Hits rejected by the screen guard.
    sat_cnt32 u_clip_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (drop_c),
        .count (clip_cnt_RnnnnU)
    );

`ifdef HIT_STATS_EN
    logic hit_out_c;

    // A hit counts once it leaves R18 on an advancing cycle.
    assign hit_out_c = en_c & hit_valid_R18H[0];

    sat_cnt32 u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (hit_out_c),
        .count (hit_cnt_RnnnnU)
    );
`endif

endmodule : hit_retime

// File: tb/tb_hit_retime.sv
// ---------------------------------------------------------------------------
// tb_hit_retime: self-checking bench for hit_retime. A queue-based model of
// "what reaches zbuff two advancing cycles later" runs alongside directed
// tables, hand sequences and random traffic.
// ---------------------------------------------------------------------------
module tb_hit_retime;
    import rast_pkg::*;

    localparam int K = 1024;

    logic                        clk;
    logic                        rst;
    logic                        halt_RnnnnL;
    fixp_t [1:0]                 screen_RnnnnS;
    fixp_t [VERTS-1:0][AXIS-1:0] tri_R16S;
    chan_t [COLORS-1:0]          color_R16U;
    fixp_t [1:0]                 sample_R16S;
    logic                        validSamp_R16H;
    logic                        hit_R16H;
    fixp_t [0:0][AXIS-1:0]       hit_R18S;
    chan_t [COLORS-1:0]          color_R18U;
    logic  [0:0]                 hit_valid_R18H;
    cnt_t                        clip_cnt_RnnnnU;
`ifdef HIT_STATS_EN
    cnt_t                        hit_cnt_RnnnnU;
`endif

    hit_retime dut (
        .clk             (clk),
        .rst             (rst),
        .halt_RnnnnL     (halt_RnnnnL),
        .screen_RnnnnS   (screen_RnnnnS),
        .tri_R16S        (tri_R16S),
        .color_R16U      (color_R16U),
        .sample_R16S     (sample_R16S),
        .validSamp_R16H  (validSamp_R16H),
        .hit_R16H        (hit_R16H),
        .hit_R18S        (hit_R18S),
        .color_R18U      (color_R18U),
        .hit_valid_R18H  (hit_valid_R18H),
`ifdef HIT_STATS_EN
        .hit_cnt_RnnnnU  (hit_cnt_RnnnnU),
`endif
        .clip_cnt_RnnnnU (clip_cnt_RnnnnU)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a fragment is "what zbuff sees"; the queue holds the
    // fragments accepted on the last two advancing cycles, oldest first.
    typedef struct {
        bit           v;
        int           x;
        int           y;
        int           z;
        logic [71:0]  c;
    } frag_t;

    frag_t    pq[$];
    longint   m_clip;
    longint   m_hits;
    int       scr_w;
    int       scr_h;

    typedef struct {
        bit r;
        bit vs;
        bit ht;
        int x;
        int y;
        bit ev;
        int ex;
        int ey;
        int eclip;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic frag_t zero_frag();
        frag_t f;
        f.v = 1'b0; f.x = 0; f.y = 0; f.z = 0; f.c = '0;
        return f;
    endfunction

    function automatic longint sat_inc(input longint v);
        return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
    endfunction

    // Apply one cycle of inputs, advance the model at the edge, check outputs after it.
    task automatic cycle(input bit r, input bit h, input int x, input int y, input int z,
                         input logic [71:0] c, input bit vs, input bit ht);
        frag_t nf;
        bit    q;
        bit    g;
        rst            = r;
        halt_RnnnnL    = h;
        screen_RnnnnS[0] = fixp_t'(scr_w);
        screen_RnnnnS[1] = fixp_t'(scr_h);
        sample_R16S[0] = fixp_t'(x);
        sample_R16S[1] = fixp_t'(y);
        for (int v = 0; v < int'(VERTS); v++)
            for (int a = 0; a < int'(AXIS); a++)
                tri_R16S[v][a] = fixp_t'($urandom);
        tri_R16S[0][2] = fixp_t'(z);
        color_R16U     = c;
        validSamp_R16H = vs;
        hit_R16H       = ht;
        @(posedge clk);
        if (r) begin
            pq.delete();
            pq.push_back(zero_frag());
            pq.push_back(zero_frag());
            m_clip = 0;
            m_hits = 0;
        end else if (h) begin
            if (pq[0].v) m_hits = sat_inc(m_hits);
            q = vs && ht;
            g = (x >= 0) && (y >= 0) && (x < scr_w) && (y < scr_h);
            if (q && !g) m_clip = sat_inc(m_clip);
            nf.v = q && g; nf.x = x; nf.y = y; nf.z = z; nf.c = c;
            pq.push_back(nf);
            void'(pq.pop_front());
        end
        #1;
        chk("valid", 80'(hit_valid_R18H), 80'(pq[0].v));
        if (pq[0].v) begin
            chk("hit_x", 80'($signed(hit_R18S[0][0])), 80'(pq[0].x));
            chk("hit_y", 80'($signed(hit_R18S[0][1])), 80'(pq[0].y));
            chk("hit_z", 80'($signed(hit_R18S[0][2])), 80'(pq[0].z));
            chk("color", 80'(color_R18U), 80'(pq[0].c));
        end
        chk("clip_cnt", 80'(clip_cnt_RnnnnU), 80'(m_clip));
`ifdef HIT_STATS_EN
        chk("hit_cnt", 80'(hit_cnt_RnnnnU), 80'(m_hits));
`endif
    endtask

    task automatic idle(input bit h);
        cycle(1'b0, h, 0, 0, 0, '0, 1'b0, 1'b0);
    endtask

    logic [71:0] col;
    int          nval;

    initial begin
        rst = 1'b1; halt_RnnnnL = 1'b1; screen_RnnnnS = '0; tri_R16S = '0;
        color_R16U = '0; sample_R16S = '0; validSamp_R16H = 1'b0; hit_R16H = 1'b0;
        scr_w = 640 * K;
        scr_h = 480 * K;
        col   = 72'h0A_BCDE_F012_3456_789A;

        // Directed table: first hit latency, no-hit, off-screen drops, right-edge hit.
        tbl[0]  = '{1, 0, 0, 0,         0,      0, 0,         0,      0};
        tbl[1]  = '{0, 1, 1, 5*K,       7*K,    0, 0,         0,      0};
        tbl[2]  = '{0, 0, 0, 0,         0,      1, 5*K,       7*K,    0};
        tbl[3]  = '{0, 0, 0, 0,         0,      0, 0,         0,      0};
        tbl[4]  = '{0, 1, 0, 5*K,       7*K,    0, 0,         0,      0};
        tbl[5]  = '{0, 0, 0, 0,         0,      0, 0,         0,      0};
        tbl[6]  = '{0, 0, 0, 0,         0,      0, 0,         0,      0};
        tbl[7]  = '{0, 1, 1, 640*K,     7*K,    0, 0,         0,      1};
        tbl[8]  = '{0, 1, 1, -K,        7*K,    0, 0,         0,      2};
        tbl[9]  = '{0, 0, 0, 0,         0,      0, 0,         0,      2};
        tbl[10] = '{0, 0, 0, 0,         0,      0, 0,         0,      2};
        tbl[11] = '{0, 1, 1, 640*K-1,   479*K,  0, 0,         0,      2};
        tbl[12] = '{0, 0, 0, 0,         0,      1, 640*K-1,   479*K,  2};
        tbl[13] = '{0, 0, 0, 0,         0,      0, 0,         0,      2};

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].r, 1'b1, tbl[i].x, tbl[i].y, 32'h1234, col, tbl[i].vs, tbl[i].ht);
            chk($sformatf("tbl%0d_valid", i), 80'(hit_valid_R18H), 80'(tbl[i].ev));
            chk($sformatf("tbl%0d_clip", i), 80'(clip_cnt_RnnnnU), 80'(tbl[i].eclip));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_x", i), 80'($signed(hit_R18S[0][0])), 80'(tbl[i].ex));
                chk($sformatf("tbl%0d_y", i), 80'($signed(hit_R18S[0][1])), 80'(tbl[i].ey));
                chk($sformatf("tbl%0d_z", i), 80'($signed(hit_R18S[0][2])), 80'(32'h1234));
            end
        end

        // Halt with a hit in R17: outputs frozen, hit appears on first enabled cycle.
        cycle(1'b1, 1'b1, 0, 0, 0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 10*K, 20*K, 77, col, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 900*K, 3*K, 5, '1, 1'b1, 1'b1);
            chk("halt_valid", 80'(hit_valid_R18H), 80'(0));
            chk("halt_clip", 80'(clip_cnt_RnnnnU), 80'(0));
        end
        idle(1'b1);
        chk("release_valid", 80'(hit_valid_R18H), 80'(1));
        chk("release_x", 80'($signed(hit_R18S[0][0])), 80'(10*K));
        chk("release_z", 80'($signed(hit_R18S[0][2])), 80'(77));
        idle(1'b0);
        chk("held_valid", 80'(hit_valid_R18H), 80'(1));
        idle(1'b1);
        chk("drain_valid", 80'(hit_valid_R18H), 80'(0));

        // Back-to-back hits for 100 cycles.
        cycle(1'b1, 1'b1, 0, 0, 0, '0, 1'b0, 1'b0);
        nval = 0;
        for (int i = 0; i < 103; i++) begin
            if (i < 100) cycle(1'b0, 1'b1, i*K, i, i+1, col, 1'b1, 1'b1);
            else         idle(1'b1);
            if (hit_valid_R18H[0]) begin
                chk("b2b_order", 80'($signed(hit_R18S[0][0])), 80'(nval*K));
                nval++;
            end
        end
        chk("b2b_count", 80'(nval), 80'(100));
`ifdef HIT_STATS_EN
        chk("b2b_hit_cnt", 80'(hit_cnt_RnnnnU), 80'(100));
`endif

        // Reset with hits in R17/R18 and a nonzero clip count.
        cycle(1'b0, 1'b1, -5, 0, 0, col, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1*K, 1*K, 9, col, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 2*K, 2*K, 9, col, 1'b1, 1'b1);
        chk("pre_rst_valid", 80'(hit_valid_R18H), 80'(1));
        cycle(1'b1, 1'b0, 3*K, 3*K, 9, col, 1'b1, 1'b1);
        chk("rst_valid", 80'(hit_valid_R18H), 80'(0));
        chk("rst_clip", 80'(clip_cnt_RnnnnU), 80'(0));
        cycle(1'b0, 1'b1, 4*K, 4*K, 11, col, 1'b1, 1'b1);
        chk("post_rst_r17", 80'(hit_valid_R18H), 80'(0));
        idle(1'b1);
        chk("post_rst_valid", 80'(hit_valid_R18H), 80'(1));
        chk("post_rst_x", 80'($signed(hit_R18S[0][0])), 80'(4*K));

        // Random traffic, occasional halts, resets and screen changes.
        for (int i = 0; i < 400; i++) begin
            bit r;
            bit h;
            int x;
            int y;
            int z;
            r = ($urandom_range(0, 49) == 0);
            h = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                scr_w = int'($urandom_range(100*K, 700*K));
                scr_h = int'($urandom_range(100*K, 520*K));
            end
            x = int'($urandom_range(0, 700*K)) - 4096;
            y = int'($urandom_range(0, 520*K)) - 4096;
            z = int'($urandom_range(0, 16777215)) - 8388608;
            col = {8'($urandom), 32'($urandom), 32'($urandom)};
            cycle(r, h, x, y, z, col, 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hit_retime
